// File: rtl/fetch_seq_if.sv
// fetch_seq_if: bundles every handshake/bus signal of the fetch sequencer.
//   imem_*  : instruction-memory request/response (req held until ack)
//   if_*    : one-entry output register towards decode, with id_ready
//   redir_* : redirect from the jump-target unit, plus branch_taken
//   trap_valid : one-cycle pulse on a misaligned redirect (optional feature)
// modport master is the sequencer side; modport slave is its environment.
interface fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [6:0]  redir_opcode;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        branch_taken;
    logic        trap_valid;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, trap_valid,
        input  imem_ack, imem_rdata, id_ready, redir_opcode, redir_valid,
               redir_target, branch_taken
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, trap_valid,
        output imem_ack, imem_rdata, id_ready, redir_opcode, redir_valid,
               redir_target, branch_taken
    );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer for the single-issue RISC-V core.
// Owns the PC, issues instruction-memory requests, presents fetched words to
// decode through a one-entry output register and applies JAL/JALR/taken-BRANCH
// redirects. Absorbs decode stalls (HOLD) and memory wait states (DRAIN).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fetch_seq_if.master (imem request/response, decode output,
//          redirect inputs, trap_valid)
// Optional feature: define MISALIGN_TRAP_EN to divert redirects whose target
// has bit 1 set to TRAP_VEC and pulse trap_valid; otherwise the target is
// word-aligned by clearing bits [1:0] and trap_valid is constant 0.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst,
    fetch_seq_if.master   bus
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;   // address of the request being drained
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        take;
    logic [31:0] new_pc;
    logic        out_free;
    logic        req;

    always_comb begin
        take = bus.redir_valid &
               ((bus.redir_opcode == OP_JAL) || (bus.redir_opcode == OP_JALR) ||
                ((bus.redir_opcode == OP_BRANCH) && bus.branch_taken));
`ifdef MISALIGN_TRAP_EN
        new_pc = bus.redir_target[1] ? TRAP_VEC : (bus.redir_target & 32'hFFFF_FFFE);
`else
        new_pc = bus.redir_target & 32'hFFFF_FFFC;
`endif
        out_free = !if_valid_q || bus.id_ready;
        // A new fetch is only issued when its result has somewhere to land;
        // a drain keeps the in-flight request alive until memory answers.
        req = ((state_q == REQ) && out_free) || (state_q == DRAIN);
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign trap_d         = take && bus.redir_target[1];
    assign bus.trap_valid = trap_q;
`else
    assign bus.trap_valid = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        // Decode consumes the entry on if_valid & id_ready in any state.
        if_valid_d   = if_valid_q && !bus.id_ready;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (take) pc_d = new_pc;
            end
            REQ: begin
                if (take) begin
                    // Redirect kills whatever would load this cycle.
                    if_valid_d = 1'b0;
                    pc_d       = new_pc;
                    if (req && !bus.imem_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (req && bus.imem_ack) begin
                    if_instr_d = bus.imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else if (!out_free) begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                if (take) pc_d = new_pc;
                if (bus.imem_ack) state_d = REQ;
            end
            HOLD: begin
                if (take) begin
                    if_valid_d = 1'b0;
                    pc_d       = new_pc;
                    state_d    = REQ;
                end else if (bus.id_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, so if_instr/if_pc
            // read 0 out of reset rather than stale data.
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc_q      <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // of this cycle regardless of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
`ifdef MISALIGN_TRAP_EN
            trap_q       <= trap_d;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: self-checking bench for fetch_seq.
// A memory model answers requests with a fixed word per address; the reference
// model tracks the architectural instruction stream (next pc = pc+4, or the
// redirect target on a taken JAL/JALR/BRANCH). The stimulus side pushes the
// expected next pc into a scoreboard queue; the monitor pops and compares on
// every decode handshake. Directed cycles check the exact fetch timing.
module tb_fetch_seq;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [6:0]  JAL    = 7'b1101111;
    localparam logic [6:0]  JALR   = 7'b1100111;
    localparam logic [6:0]  BRANCH = 7'b1100011;
    localparam logic [6:0]  AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPREG  = 7'b0110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_seq_if bus();

    fetch_seq #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int consumed    = 0;

    // stimulus globals, applied by run() just after each rising edge
    logic        rst_s = 1'b1, rdy_s = 1'b1, rv_s = 1'b0, bt_s = 1'b0;
    logic [6:0]  op_s  = 7'h0;
    logic [31:0] tgt_s = 32'h0;
    logic        mem_hold = 1'b0, force_ack = 1'b0;
    int          wait_max = 0, wait_cnt = 0;

    // reference model state
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc = RESET_PC;
    logic        pend_take = 1'b0, pend_trap = 1'b0, trap_exp = 1'b0;
    logic [31:0] pend_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, update the model, answer memory, then
    // return at the falling edge so the caller can sample settled outputs.
    task automatic run();
        @(posedge clk);
        #1;
        rst              = rst_s;
        bus.id_ready     = rdy_s;
        bus.redir_valid  = rv_s;
        bus.redir_opcode = op_s;
        bus.redir_target = tgt_s;
        bus.branch_taken = bt_s;
        pend_take = !rst_s && rv_s &&
                    (op_s == JAL || op_s == JALR || (op_s == BRANCH && bt_s));
`ifdef MISALIGN_TRAP_EN
        pend_trap = tgt_s[1];
        pend_pc   = tgt_s[1] ? TRAP_VEC : (tgt_s & 32'hFFFF_FFFC);
`else
        pend_trap = 1'b0;
        pend_pc   = tgt_s & 32'hFFFF_FFFC;
`endif
        if (!rst_s && sb_q.size() == 0) begin
            sb_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        #1;
        if (force_ack) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
        end else if (bus.imem_req === 1'b1 && !mem_hold && wait_cnt == 0) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            wait_cnt       = $urandom_range(wait_max, 0);
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            if (bus.imem_req === 1'b1 && wait_cnt > 0) wait_cnt--;
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares on every decode handshake, then applies the redirect.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_pc   = RESET_PC;
            trap_exp = 1'b0;
        end else begin
            check("trap_valid", {31'h0, bus.trap_valid}, {31'h0, trap_exp});
            if (bus.if_valid && bus.id_ready) begin
                consumed++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'h1, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check("if_pc", bus.if_pc, e);
                    check("if_instr", bus.if_instr, mem_word(e));
                end
            end
            trap_exp = pend_take && pend_trap;
            if (pend_take) begin
                sb_q.delete();
                exp_pc = pend_pc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack = 1'b0;  bus.imem_rdata = 32'h0;  bus.id_ready = 1'b1;
        bus.redir_valid = 1'b0;  bus.redir_opcode = 7'h0;
        bus.redir_target = 32'h0;  bus.branch_taken = 1'b0;

        // reset values
        rst_s = 1'b1;  run();  run();
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_instr", bus.if_instr, 32'h0);
        check("rst_trap", {31'h0, bus.trap_valid}, 32'h0);

        // IDLE for one cycle, then back-to-back zero-wait fetches
        rst_s = 1'b0;  run();
        check("idle_req", {31'h0, bus.imem_req}, 32'h0);
        run();  check("addr0", bus.imem_addr, 32'h0);
        check("req_after_idle", {31'h0, bus.imem_req}, 32'h1);
        run();  check("addr4", bus.imem_addr, 32'h4);
        check("valid_c2", {31'h0, bus.if_valid}, 32'h1);
        check("if_pc_c2", bus.if_pc, 32'h0);
        run();  check("addr8", bus.imem_addr, 32'h8);
        run();  check("addrC", bus.imem_addr, 32'hC);

        // JAL while a request waits -> drain the stale ack, then fetch 0x40
        mem_hold = 1'b1;  run();
        rv_s = 1'b1;  op_s = JAL;  tgt_s = 32'h40;  run();
        check("pre_drain_addr", bus.imem_addr, 32'h10);
        rv_s = 1'b0;  mem_hold = 1'b0;  run();
        check("drain_addr", bus.imem_addr, 32'h10);
        check("drain_valid", {31'h0, bus.if_valid}, 32'h0);
        run();  check("jal_addr", bus.imem_addr, 32'h40);
        check("jal_req", {31'h0, bus.imem_req}, 32'h1);

        // not-taken BRANCH and AUIPC never redirect
        rv_s = 1'b1;  op_s = BRANCH;  bt_s = 1'b0;  tgt_s = 32'h80;  run();
        check("jal_if_pc", bus.if_pc, 32'h40);
        op_s = AUIPC;  run();  check("br_nt_addr", bus.imem_addr, 32'h48);
        op_s = JALR;  tgt_s = 32'h101;  run();  check("auipc_addr", bus.imem_addr, 32'h4C);
        tgt_s = 32'h102;  run();  check("jalr_addr", bus.imem_addr, 32'h100);
        check("jalr_kill", {31'h0, bus.if_valid}, 32'h0);
        rv_s = 1'b0;  run();  check("mis_addr", bus.imem_addr, 32'h100);
`ifdef MISALIGN_TRAP_EN
        check("mis_trap", {31'h0, bus.trap_valid}, 32'h1);
`else
        check("mis_trap", {31'h0, bus.trap_valid}, 32'h0);
`endif

        // decode stall for 3 cycles, JAL to 0x200 in the last one
        rdy_s = 1'b0;  run();
        check("stall_req0", {31'h0, bus.imem_req}, 32'h0);
        check("stall_pc0", bus.if_pc, 32'h100);
        run();  check("stall_req1", {31'h0, bus.imem_req}, 32'h0);
        check("stall_instr", bus.if_instr, mem_word(32'h100));
        rv_s = 1'b1;  op_s = JAL;  tgt_s = 32'h200;  run();
        check("stall_req2", {31'h0, bus.imem_req}, 32'h0);
        check("stall_pc2", bus.if_pc, 32'h100);
        rv_s = 1'b0;  rdy_s = 1'b1;  mem_hold = 1'b1;  run();
        check("hold_kill", {31'h0, bus.if_valid}, 32'h0);
        check("hold_jal_addr", bus.imem_addr, 32'h200);

        // reset while draining; the late ack lands in IDLE and is ignored
        rv_s = 1'b1;  tgt_s = 32'h300;  run();
        rv_s = 1'b0;  rst_s = 1'b1;  run();
        check("drain2_addr", bus.imem_addr, 32'h200);
        rst_s = 1'b0;  mem_hold = 1'b0;  force_ack = 1'b1;  run();
        check("late_ack_req", {31'h0, bus.imem_req}, 32'h0);
        check("late_ack_valid", {31'h0, bus.if_valid}, 32'h0);
        force_ack = 1'b0;  run();
        check("restart_addr", bus.imem_addr, RESET_PC);
        check("restart_valid", {31'h0, bus.if_valid}, 32'h0);

        // PC wrap
        rv_s = 1'b1;  tgt_s = 32'hFFFF_FFFC;  run();
        rv_s = 1'b0;  run();  check("wrap_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
        run();  check("wrap_addr_0", bus.imem_addr, 32'h0);
        check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);

        // randomized traffic: wait states, stalls, redirects, rare resets
        wait_max = 2;
        for (int i = 0; i < 3000; i++) begin
            rst_s = ($urandom_range(299, 0) == 0);
            rdy_s = ($urandom_range(3, 0) != 0);
            rv_s  = !rst_s && ($urandom_range(5, 0) == 0);
            case ($urandom_range(4, 0))
                0:       op_s = JAL;
                1:       op_s = JALR;
                2:       op_s = BRANCH;
                3:       op_s = AUIPC;
                default: op_s = OPREG;
            endcase
            bt_s  = 1'($urandom_range(1, 0));
            tgt_s = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : ($urandom & 32'hFFF);
            run();
        end
        rst_s = 1'b0;  rv_s = 1'b0;  run();
        check("progress", (consumed > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Program-counter sequencer for the single-issue RISC-V core. It owns the PC and issues instruction-memory requests.
- It presents fetched words to decode through a one-entry output register.
- It applies redirects from the jump-target unit: JAL, JALR and taken BRANCH. AUIPC is never a redirect.
- It sits between instruction memory and decode, and absorbs decode stalls and memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned redirect (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  response valid this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- id_ready  in  1  decode accepts the output register this cycle.
- redir_opcode  in  7  opcode of the resolving instruction.
- redir_valid  in  1  redir_opcode/redir_target valid this cycle.
- redir_target  in  32  computed target (PC_jmp).
- branch_taken  in  1  ALU branch condition; only meaningful for BRANCH.
- trap_valid  out  1  one-cycle pulse on misaligned redirect (optional feature; tied 0 otherwise).

Behaviour:
- Redirect condition: take = redir_valid & (opcode==JAL | opcode==JALR | (opcode==BRANCH & branch_taken)). Opcode values come from the shared util.v defines.
- Redirect target: new_pc = {redir_target[31:1],1'b0}. Bit 0 is cleared, which is the JALR rule applied uniformly.
- PC increment: pc+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Reset (rst=1 at an edge): pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, trap_valid=0. Reset aborts any outstanding request; a late imem_ack is ignored while in IDLE.
- IDLE: go to REQ on the next cycle with rst=0.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack & !take & output free: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4; stay REQ. Throughput is one instruction per cycle with zero-wait memory.
  - Output free means !if_valid | id_ready.
  - imem_ack & output not free: cannot occur, because imem_req is driven only when the output is free. If the output becomes not free, go to HOLD with imem_req=0.
  - take & imem_ack same cycle: discard rdata, if_valid<=0, pc<=new_pc; stay REQ.
  - take & !imem_ack: if_valid<=0, pc<=new_pc, go to DRAIN. The in-flight request is held until acked.
- DRAIN: imem_req=1, imem_addr=old address, which is held in an internal register.
  - On imem_ack: discard rdata, go to REQ at pc.
  - Another take in DRAIN overwrites pc with the newest target.
- HOLD (if_valid=1, id_ready=0): imem_req=0, registers frozen. Go to REQ when id_ready=1. In that same cycle the entry is consumed: if_valid<=0, unless a fetch completes.
- Redirect has priority over stall in every state: take in HOLD gives if_valid<=0, pc<=new_pc, go to REQ.
- Handshake with decode: an instruction is consumed on a cycle with if_valid & id_ready. Any take in the same cycle kills the entry that would otherwise load.
- Latency:
  - rst deassert to first imem_req: 1 cycle.
  - take to imem_addr=new_pc: next cycle if no request is outstanding; otherwise after the drain ack.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: on take with new_pc[1]=1, the fetch sequencer does not redirect to new_pc. It sets pc<=TRAP_VEC, pulses trap_valid for exactly 1 cycle, and applies the same kill/drain rules.
- Undefined: bit 1 is also cleared (new_pc={redir_target[31:2],2'b00}) and trap_valid is constant 0.

Test Plan:
- Reset then zero-wait memory with id_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; if_pc follows one cycle later; if_valid=1 from cycle 2.
- JAL with redir_target=32'h40 while in REQ with no ack -> DRAIN; the stale ack is discarded; next imem_addr=32'h40; if_valid=0 for the killed slot.
- BRANCH with branch_taken=0 and target 32'h80 -> no redirect, sequential fetch continues. AUIPC with redir_valid=1 -> no redirect.
- JALR with target 32'h101 -> imem_addr=32'h100. With MISALIGN_TRAP_EN and target 32'h102 -> imem_addr=TRAP_VEC (32'h100), trap_valid high for 1 cycle.
- id_ready=0 for 3 cycles while if_valid=1 -> imem_req=0, if_instr/if_pc stable. A taken JAL to 32'h200 during the stall -> if_valid=0 next cycle, then fetch at 32'h200.
- rst asserted while in DRAIN, with ack arriving the next cycle -> ack ignored, if_valid=0, first fetch at RESET_PC after release. Wrap case: pc=32'hFFFF_FFFC fetch -> next imem_addr=0.
